// File: rtl/tetris_pkg.sv
// Shared encodings for the Tetris game-mode controller.
package tetris_pkg;

  localparam int TMR_W = 30;

  typedef enum logic [1:0] {
    SC_START = 2'b00,
    SC_PLAY  = 2'b01,
    SC_PAUSE = 2'b10,
    SC_OVER  = 2'b11
  } scene_t;

endpackage

// File: rtl/drop_period.sv
// Level-to-gravity-period mapping: BASE_DROP - level*DROP_STEP, floored at MIN_DROP.
module drop_period
  import tetris_pkg::*;
#(
  parameter int BASE_DROP = 25000000,
  parameter int DROP_STEP = 2000000,
  parameter int MIN_DROP  = 2500000
) (
  input  logic [3:0]       level,
  output logic [TMR_W-1:0] period
);

  // Headroom so the subtraction goes negative instead of wrapping.
  localparam int PW = TMR_W + 8;
  localparam logic signed [PW-1:0] BASE_S = PW'(BASE_DROP);
  localparam logic signed [PW-1:0] STEP_S = PW'(DROP_STEP);
  localparam logic signed [PW-1:0] MIN_S  = PW'(MIN_DROP);

  function automatic logic [TMR_W-1:0] clamp_period(input logic signed [PW-1:0] raw);
    logic [TMR_W-1:0] res;
    if (raw < MIN_S) res = TMR_W'(MIN_DROP);
    else             res = raw[TMR_W-1:0];
    return res;
  endfunction

  logic signed [PW-1:0] level_s;
  logic signed [PW-1:0] raw;

  assign level_s = $signed({{(PW-4){1'b0}}, level});
  assign raw     = BASE_S - level_s * STEP_S;
  assign period  = clamp_period(raw);

endmodule

// File: rtl/scene_sequencer.sv
// Tetris scene FSM (START/PLAY/PAUSE/OVER) sharing one timer for title animation,
// gravity ticks and the game-over hold.
module scene_sequencer
  import tetris_pkg::*;
#(
  parameter int FRAME_TICKS     = 25000000,
  parameter int BASE_DROP       = 25000000,
  parameter int DROP_STEP       = 2000000,
  parameter int MIN_DROP        = 2500000,
  parameter int OVER_TICKS      = 100000000,
  parameter int LINES_PER_LEVEL = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_key,
  input  logic       pause_key,
  input  logic       game_over,
  input  logic       line_clr,
  output logic [1:0] scene,
  output logic [1:0] anim_frame,
  output logic       drop_tick,
  output logic       board_clr,
  output logic [3:0] level
);

  localparam int LW = (LINES_PER_LEVEL > 1) ? $clog2(LINES_PER_LEVEL) : 1;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    logic [3:0] res;
    if (v == 4'd15) res = v;
    else            res = v + 4'd1;
    return res;
  endfunction

  scene_t           state_q, state_nxt;
  logic [TMR_W-1:0] cnt_q, cnt_nxt;
  logic [TMR_W-1:0] period;
  logic [1:0]       anim_q, anim_nxt;
  logic             drop_q, drop_nxt;
  logic             clr_q, clr_nxt;
  logic [3:0]       level_q, level_nxt;
  logic [LW-1:0]    lines_q, lines_nxt;
  logic             frame_done, over_done, drop_due;

  drop_period #(
    .BASE_DROP(BASE_DROP),
    .DROP_STEP(DROP_STEP),
    .MIN_DROP (MIN_DROP)
  ) u_drop_period (
    .level (level_q),
    .period(period)
  );

  assign frame_done = (cnt_q == TMR_W'(FRAME_TICKS - 1));
  assign over_done  = (cnt_q == TMR_W'(OVER_TICKS - 1));
  // >= so a period that shrinks below the running count still fires next edge.
  assign drop_due   = (cnt_q >= period - TMR_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SC_START;
      cnt_q   <= '0;
      anim_q  <= '0;
      drop_q  <= 1'b0;
      clr_q   <= 1'b0;
      level_q <= '0;
      lines_q <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      anim_q  <= anim_nxt;
      drop_q  <= drop_nxt;
      clr_q   <= clr_nxt;
      level_q <= level_nxt;
      lines_q <= lines_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      SC_START: if (start_key) state_nxt = SC_PLAY;
      SC_PLAY: begin
        if (game_over)      state_nxt = SC_OVER;
        else if (pause_key) state_nxt = SC_PAUSE;
      end
      SC_PAUSE: if (pause_key) state_nxt = SC_PLAY;
      SC_OVER:  if (over_done) state_nxt = SC_START;
      default:  state_nxt = SC_START;
    endcase
  end

  always_comb begin
    cnt_nxt   = cnt_q;
    anim_nxt  = anim_q;
    drop_nxt  = 1'b0;
    clr_nxt   = 1'b0;
    level_nxt = level_q;
    lines_nxt = lines_q;
    case (state_q)
      SC_START: begin
        if (start_key) begin
          cnt_nxt   = '0;
          level_nxt = '0;
          lines_nxt = '0;
          clr_nxt   = 1'b1;
        end else if (frame_done) begin
          cnt_nxt  = '0;
          anim_nxt = anim_q + 2'd1;
        end else begin
          cnt_nxt = cnt_q + TMR_W'(1);
        end
      end
      SC_PLAY: begin
        if (line_clr) begin
          if (lines_q == LW'(LINES_PER_LEVEL - 1)) begin
            lines_nxt = '0;
            level_nxt = sat_inc(level_q);
          end else begin
            lines_nxt = lines_q + LW'(1);
          end
        end
        if (game_over) begin
          cnt_nxt = '0;
        end else if (pause_key) begin
          cnt_nxt = cnt_q;
        end else if (drop_due) begin
          cnt_nxt  = '0;
          drop_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_q + TMR_W'(1);
        end
      end
      SC_OVER: begin
        if (over_done) begin
          cnt_nxt  = '0;
          anim_nxt = '0;
        end else begin
          cnt_nxt = cnt_q + TMR_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign scene      = state_q;
  assign anim_frame = anim_q;
  assign drop_tick  = drop_q;
  assign board_clr  = clr_q;
  assign level      = level_q;

endmodule

// File: tb/tb_scene_sequencer.sv
// Directed bench for scene_sequencer using small timer parameters.
module tb_scene_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_key = 1'b0;
  logic       pause_key = 1'b0;
  logic       game_over = 1'b0;
  logic       line_clr = 1'b0;
  logic [1:0] scene;
  logic [1:0] anim_frame;
  logic       drop_tick;
  logic       board_clr;
  logic [3:0] level;

  int errors = 0;
  int checks = 0;

  scene_sequencer #(
    .FRAME_TICKS    (4),
    .BASE_DROP      (10),
    .DROP_STEP      (3),
    .MIN_DROP       (4),
    .OVER_TICKS     (6),
    .LINES_PER_LEVEL(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_key (start_key),
    .pause_key (pause_key),
    .game_over (game_over),
    .line_clr  (line_clr),
    .scene     (scene),
    .anim_frame(anim_frame),
    .drop_tick (drop_tick),
    .board_clr (board_clr),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_scene"}, scene, 0);
    chk({tag, "_anim"}, anim_frame, 0);
    chk({tag, "_drop"}, drop_tick, 0);
    chk({tag, "_clr"}, board_clr, 0);
    chk({tag, "_level"}, level, 0);
  endtask

  initial begin
    // Reset and idle title animation
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("reset");
    for (int i = 1; i <= 21; i++) begin
      step();
      chk("idle_anim", anim_frame, (i / 4) % 4);
      chk("idle_scene", scene, 0);
      chk("idle_drop", drop_tick, 0);
    end

    // Start game: PLAY, board clear pulse, ticks every 10
    start_key = 1'b1;
    step();
    start_key = 1'b0;
    chk("start_scene", scene, 1);
    chk("start_clr", board_clr, 1);
    chk("start_anim_held", anim_frame, 1);
    chk("start_drop", drop_tick, 0);
    for (int k = 1; k <= 33; k++) begin
      step();
      chk("play_drop", drop_tick, (k % 10 == 0) ? 1 : 0);
      chk("play_scene", scene, 1);
      if (k == 1) chk("clr_one_cycle", board_clr, 0);
    end

    // Pause with cnt=3, ignored inputs while paused, resume
    pause_key = 1'b1;
    step();
    pause_key = 1'b0;
    chk("pause_scene", scene, 2);
    chk("pause_drop", drop_tick, 0);
    for (int p = 1; p <= 50; p++) begin
      if (p == 10) begin
        line_clr  = 1'b1;
        game_over = 1'b1;
        start_key = 1'b1;
      end
      step();
      if (p == 10) begin
        game_over = 1'b0;
        start_key = 1'b0;
      end
      if (p == 11) line_clr = 1'b0;
      chk("paused_drop", drop_tick, 0);
      chk("paused_scene", scene, 2);
    end
    chk("paused_level", level, 0);
    pause_key = 1'b1;
    step();
    pause_key = 1'b0;
    chk("resume_scene", scene, 1);
    for (int j = 1; j <= 7; j++) begin
      step();
      chk("resume_drop", drop_tick, (j == 7) ? 1 : 0);
    end

    // Level-up shortens the period, with clamp at MIN_DROP
    line_clr = 1'b1;
    step();
    step();
    line_clr = 1'b0;
    chk("lvl1_level", level, 1);
    chk("lvl1_drop", drop_tick, 0);
    for (int j = 1; j <= 12; j++) begin
      step();
      chk("lvl1_drop_p7", drop_tick, (j == 5 || j == 12) ? 1 : 0);
    end
    line_clr = 1'b1;
    step();
    step();
    line_clr = 1'b0;
    chk("lvl2_level", level, 2);
    for (int j = 1; j <= 10; j++) begin
      step();
      chk("lvl2_drop_p4", drop_tick, (j % 4 == 2) ? 1 : 0);
    end
    line_clr = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      step();
      chk("lvl4_ramp_drop", drop_tick, (j == 4) ? 1 : 0);
    end
    line_clr = 1'b0;
    chk("lvl4_level", level, 4);
    for (int j = 1; j <= 8; j++) begin
      step();
      chk("lvl4_drop_clamp", drop_tick, (j % 4 == 0) ? 1 : 0);
    end

    // game_over coinciding with period expiry
    for (int j = 1; j <= 3; j++) begin
      step();
      chk("pre_over_drop", drop_tick, 0);
    end
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    chk("over_scene", scene, 3);
    chk("over_no_drop", drop_tick, 0);
    for (int j = 1; j <= 6; j++) begin
      if (j == 2) begin
        start_key = 1'b1;
        pause_key = 1'b1;
      end
      step();
      start_key = 1'b0;
      pause_key = 1'b0;
      chk("over_hold_scene", scene, (j == 6) ? 0 : 3);
      chk("over_anim", anim_frame, (j == 6) ? 0 : 1);
      chk("over_level", level, 4);
      chk("over_drop", drop_tick, 0);
    end

    // Reset mid-PLAY, with start_key competing
    start_key = 1'b1;
    step();
    start_key = 1'b0;
    chk("restart_level", level, 0);
    chk("restart_clr", board_clr, 1);
    line_clr = 1'b1;
    step();
    step();
    line_clr = 1'b0;
    chk("midplay_level", level, 1);
    rst = 1'b1;
    start_key = 1'b1;
    step();
    rst = 1'b0;
    start_key = 1'b0;
    chk_reset("rst_play");

    // Reset mid-PAUSE
    start_key = 1'b1;
    step();
    start_key = 1'b0;
    line_clr = 1'b1;
    step();
    step();
    line_clr = 1'b0;
    pause_key = 1'b1;
    step();
    pause_key = 1'b0;
    chk("midpause_scene", scene, 2);
    chk("midpause_level", level, 1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("rst_pause");
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 3) chk("post_rst_anim3", anim_frame, 0);
      if (i == 4) chk("post_rst_anim4", anim_frame, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
